// File: rtl/pipelined_mult.sv
// pipelined_mult: 3-stage binary32 multiplier; define ROUND_NEAREST_EN for round-to-nearest-even, otherwise truncation
module pipelined_mult (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [31:0] A,
  input  logic [31:0] B,
  output logic [31:0] C,
  output logic        error_flag
);
`ifdef ROUND_NEAREST_EN
  localparam logic round_en = 1'b1;
`else
  localparam logic round_en = 1'b0;
`endif
  logic               a_zero, b_zero, a_inf, b_inf, a_nan, b_nan;
  logic               s1_sign, s1_nan, s1_inf, s1_zero;
  logic signed [9:0]  s1_exp;
  logic [23:0]        s1_ma, s1_mb;
  logic               s2_sign, s2_nan, s2_inf, s2_zero;
  logic signed [9:0]  s2_exp;
  logic [47:0]        s2_prod;
  logic               norm, rnd, ovf, unf;
  logic [22:0]        mant;
  logic [23:0]        sum;
  logic signed [9:0]  e;
  logic [32:0]        res;
  // classify operands; denormals count as zero so they flush without a flag
  always_comb begin
    a_zero = A[30:23] == 8'h00;
    b_zero = B[30:23] == 8'h00;
    a_inf  = A[30:23] == 8'hFF && A[22:0] == 23'h0;
    b_inf  = B[30:23] == 8'hFF && B[22:0] == 23'h0;
    a_nan  = A[30:23] == 8'hFF && A[22:0] != 23'h0;
    b_nan  = B[30:23] == 8'hFF && B[22:0] != 23'h0;
  end
  // stage 1: unpack sign, biased exponent sum, significands and special class
  always_ff @(posedge clk) begin
    if (rst_n) begin
      s1_sign <= 1'b0;
      s1_exp  <= '0;
      s1_ma   <= '0;
      s1_mb   <= '0;
      s1_nan  <= 1'b0;
      s1_inf  <= 1'b0;
      s1_zero <= 1'b0;
    end else begin
      s1_sign <= A[31] ^ B[31];
      s1_exp  <= {2'b0, A[30:23]} + {2'b0, B[30:23]} - 10'd127;
      s1_ma   <= {1'b1, A[22:0]};
      s1_mb   <= {1'b1, B[22:0]};
      s1_nan  <= a_nan | b_nan | (a_inf & b_zero) | (b_inf & a_zero);
      s1_inf  <= a_inf | b_inf;
      s1_zero <= a_zero | b_zero;
    end
  end
  // stage 2: full 48-bit significand product
  always_ff @(posedge clk) begin
    if (rst_n) begin
      s2_sign <= 1'b0;
      s2_exp  <= '0;
      s2_prod <= '0;
      s2_nan  <= 1'b0;
      s2_inf  <= 1'b0;
      s2_zero <= 1'b0;
    end else begin
      s2_sign <= s1_sign;
      s2_exp  <= s1_exp;
      s2_prod <= {24'b0, s1_ma} * {24'b0, s1_mb};
      s2_nan  <= s1_nan;
      s2_inf  <= s1_inf;
      s2_zero <= s1_zero;
    end
  end
  // normalise, round, range-check and pack; a cleared pipeline has a zero product and packs to +0
  always_comb begin
    norm = s2_prod[47];
    mant = norm ? s2_prod[46:24] : s2_prod[45:23];
    rnd  = round_en & (norm ? s2_prod[23] & (|s2_prod[22:0] | s2_prod[24])
                            : s2_prod[22] & (|s2_prod[21:0] | s2_prod[23]));
    sum  = {1'b0, mant} + {23'b0, rnd};
    e    = s2_exp + {9'b0, norm} + {9'b0, sum[23]};
    ovf  = e >= 10'sd255;
    unf  = e <= 10'sd0;
    res  = s2_nan                  ? {1'b1, 32'h7FC00000} :
           s2_inf                  ? {1'b0, s2_sign, 8'hFF, 23'h0} :
           (s2_zero | ~|s2_prod)   ? {1'b0, s2_sign, 31'h0} :
           ovf                     ? {1'b1, s2_sign, 8'hFF, 23'h0} :
           unf                     ? {1'b1, s2_sign, 31'h0} :
                                     {1'b0, s2_sign, e[7:0], sum[22:0]};
  end
  // stage 3: registered result and exception flag
  always_ff @(posedge clk) begin
    if (rst_n) begin
      C          <= '0;
      error_flag <= 1'b0;
    end else begin
      C          <= res[31:0];
      error_flag <= res[32];
    end
  end
endmodule

// File: tb/tb_pipelined_mult.sv
// tb_pipelined_mult: directed and random checks of pipelined_mult against a behavioural reference
module tb_pipelined_mult;
`ifdef ROUND_NEAREST_EN
  localparam bit rne = 1'b1;
`else
  localparam bit rne = 1'b0;
`endif
  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic [31:0] A = '0, B = '0, C;
  logic        error_flag;
  int          total = 0, passed = 0;
  logic [32:0] pipe [2];
  logic [32:0] mexp;
  pipelined_mult dut (.clk(clk), .rst_n(rst_n), .A(A), .B(B), .C(C), .error_flag(error_flag));
  always #5 clk = ~clk;
  function automatic logic [32:0] ref_mul(input logic [31:0] a, input logic [31:0] b);
    logic s;
    int ea, eb, be;
    bit za, zb, ia, ib, na, nb, g, st;
    longint m;
    s  = a[31] ^ b[31];
    ea = int'(a[30:23]);
    eb = int'(b[30:23]);
    za = ea == 0;
    zb = eb == 0;
    ia = ea == 255 && a[22:0] == 0;
    ib = eb == 255 && b[22:0] == 0;
    na = ea == 255 && a[22:0] != 0;
    nb = eb == 255 && b[22:0] != 0;
    if (na || nb || (ia && zb) || (ib && za)) return {1'b1, 32'h7FC00000};
    if (ia || ib) return {1'b0, s, 8'hFF, 23'h0};
    if (za || zb) return {1'b0, s, 31'h0};
    m  = longint'({1'b1, a[22:0]}) * longint'({1'b1, b[22:0]});
    be = ea + eb - 127 - 23;
    g  = 0;
    st = 0;
    while (m >= 64'd16777216) begin
      st = st | g;
      g  = m[0];
      m  = m >> 1;
      be++;
    end
    if (rne && g && (st || m[0])) m++;
    if (m == 64'd16777216) begin
      m = m >> 1;
      be++;
    end
    if (be >= 255) return {1'b1, s, 8'hFF, 23'h0};
    if (be <= 0) return {1'b1, s, 31'h0};
    return {1'b0, s, be[7:0], m[22:0]};
  endfunction
  task automatic chk(input string tag, input logic [32:0] got, input logic [32:0] exp);
    total++;
    assert (got === exp) passed++;
    else $error("FAIL %s: got flag=%0b C=%08h, expected flag=%0b C=%08h", tag, got[32], got[31:0], exp[32], exp[31:0]);
  endtask
  task automatic step(input logic r, input logic [31:0] a, input logic [31:0] b);
    rst_n = r;
    A = a;
    B = b;
    @(posedge clk);
    if (r) begin
      mexp = '0;
      pipe[0] = '0;
      pipe[1] = '0;
    end else begin
      mexp = pipe[1];
      pipe[1] = pipe[0];
      pipe[0] = ref_mul(a, b);
    end
    #1 chk("pipe", {error_flag, C}, mexp);
  endtask
  task automatic vec(input string tag, input logic [31:0] a, input logic [31:0] b, input logic [32:0] exp);
    repeat (3) step(1'b0, a, b);
    chk(tag, {error_flag, C}, exp);
  endtask
  initial begin
    logic [31:0] ra, rb;
    pipe[0] = '0;
    pipe[1] = '0;
    mexp = '0;
    step(1'b1, 32'h41360000, 32'h41a4c000);
    chk("rst0", {error_flag, C}, 33'h0);
    step(1'b1, 32'h41360000, 32'h41a4c000);
    chk("rst1", {error_flag, C}, 33'h0);
    step(1'b0, 32'h41360000, 32'h41a4c000);
    chk("post_rst_e1", {error_flag, C}, 33'h0);
    step(1'b0, 32'h41360000, 32'h41a4c000);
    chk("post_rst_e2", {error_flag, C}, 33'h0);
    step(1'b0, 32'h41360000, 32'h41a4c000);
    chk("post_rst_e3", {error_flag, C}, {1'b0, 32'h436A4100});
    step(1'b0, 32'h3FC00000, 32'h3FC00000);
    step(1'b0, 32'h3FE00000, 32'h3FE00000);
    step(1'b0, 32'h0, 32'h0);
    chk("b2b_0", {error_flag, C}, {1'b0, 32'h40100000});
    step(1'b0, 32'h0, 32'h0);
    chk("b2b_1", {error_flag, C}, {1'b0, 32'h40440000});
    vec("nan_in",    32'h7FC00000, 32'h3F800000, {1'b1, 32'h7FC00000});
    vec("inf_x_0",   32'h7F800000, 32'h00000000, {1'b1, 32'h7FC00000});
    vec("inf_x_neg", 32'h7F800000, 32'hBF800000, {1'b0, 32'hFF800000});
    vec("overflow",  32'h7F000000, 32'h7F000000, {1'b1, 32'h7F800000});
    vec("underflow", 32'h00800000, 32'h00800000, {1'b1, 32'h00000000});
    vec("neg_zero",  32'h80000000, 32'h40000000, {1'b0, 32'h80000000});
    vec("denorm",    32'h00000001, 32'hC0000000, {1'b0, 32'h80000000});
    vec("round_a",   32'h3F800001, 32'h3F800001, {1'b0, 32'h3F800002});
    vec("round_b",   32'h3FFFFFFF, 32'h3FFFFFFF, {1'b0, 32'h407FFFFE});
    for (int i = 0; i < 400; i++) begin
      ra = $urandom;
      rb = $urandom;
      if ($urandom_range(0, 3) == 0) ra[22:0] = 23'h7FFFFF;
      if ($urandom_range(0, 3) == 0) rb[30:23] = 8'd127 + 8'($urandom_range(0, 2));
      if ($urandom_range(0, 15) == 0) ra[30:23] = 8'hFF;
      step(1'b0, ra, rb);
    end
    for (int i = 0; i < 2; i++) step(1'b0, $urandom, $urandom);
    step(1'b1, $urandom, $urandom);
    chk("mid_rst", {error_flag, C}, 33'h0);
    for (int i = 0; i < 5; i++) step(1'b0, $urandom, $urandom);
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule

// File: doc/pipelined_mult.md
Name: pipelined_mult

Overview:
Fully pipelined IEEE-754 single-precision (binary32) floating-point multiplier. It accepts one operand pair per clock and returns C = A × B three cycles later, with error_flag aligned to the same result. Intended as a drop-in arithmetic unit in datapaths that need one multiply per cycle with fixed latency.

Parameters:
None. Width is fixed at 32 bits (binary32) and latency is fixed at 3.

Ports:
clk  input  1  clock; all state updates on the rising edge
rst_n  input  1  reset, synchronous, active-high (rst_n=1 resets)
A  input  32  operand A, binary32
B  input  32  operand B, binary32
C  output  32  product, binary32, registered
error_flag  output  1  exception indicator aligned with C, registered

Behaviour:
- One clock; reset is synchronous and active-high.
- Reset: on a clk edge with rst_n=1, all pipeline registers clear; C=32'h0 and error_flag=0 from that edge. This includes a reset asserted mid-operation: in-flight results are discarded.
- Pipeline:
  - Stage 1 registers the unpacked operands. It computes sign = sA^sB, the biased exponent sum eA+eB−127 (10-bit signed), 24-bit significands with the hidden bit, and special-case class.
  - Stage 2 registers the 48-bit significand product.
  - Stage 3 normalises, rounds, packs and registers C and error_flag.
- Latency is exactly 3 rising edges from A/B sampled to C valid. Throughput is 1 per cycle and there is no stall or handshake.
- After reset deasserts, C holds 0 until the first sampled operand pair emerges (3 edges later).
- Normalise: if product bit 47 is set, shift right 1 and add 1 to the exponent.
- Rounding: round-to-nearest-even using guard and sticky bits (see Optional Feature). A mantissa carry-out after rounding renormalises and adds 1 to the exponent.
- Denormal inputs (exp=0, frac≠0) are flushed to signed zero, with no flag.
- Zero × finite gives a signed zero (sign = sA^sB) and error_flag=0.
- Inf × nonzero finite or Inf × Inf gives a signed infinity and error_flag=0.
- NaN on either input gives C=32'h7FC00000 (canonical quiet NaN) and error_flag=1.
- Inf × 0 gives C=32'h7FC00000 and error_flag=1.
- Overflow (final biased exponent ≥255) gives a signed infinity (exp=FF, frac=0) and error_flag=1.
- Underflow (final biased exponent ≤0 with a nonzero finite product) gives a signed zero and error_flag=1. No denormal outputs are produced.
- error_flag=0 for all other results.

Optional Feature:
Macro ROUND_NEAREST_EN.
- Defined: round-to-nearest, ties-to-even on the 24-bit result significand.
- Undefined: truncation (round toward zero). Guard and sticky bits are ignored, and overflow arises only from the exponent.
- Exact products are identical in both builds.

Test Plan:
- Reset: hold rst_n=1 for 2 edges with A=32'h41360000, B=32'h41a4c000 -> C=32'h0 and error_flag=0 throughout reset. Release reset -> C=32'h436A4100 (11.375×20.59375=234.25390625) on the 3rd edge after release, error_flag=0.
- Back-to-back: apply A=B=32'h3FC00000, then A=B=32'h3FE00000 on consecutive cycles -> C=32'h40100000 (2.25) then 32'h40440000 (3.0625) on consecutive cycles, 3 edges after each input.
- Specials:
  - A=32'h7FC00000, B=32'h3F800000 -> C=32'h7FC00000, error_flag=1.
  - A=32'h7F800000, B=32'h00000000 -> C=32'h7FC00000, error_flag=1.
  - A=32'h7F800000, B=32'hBF800000 -> C=32'hFF800000, error_flag=0.
- Overflow/underflow:
  - A=B=32'h7F000000 -> C=32'h7F800000, error_flag=1.
  - A=B=32'h00800000 -> C=32'h00000000, error_flag=1.
  - A=32'h80000000, B=32'h40000000 -> C=32'h80000000, error_flag=0.
- Rounding: A=32'h3F800001, B=32'h3F800001.
  - With ROUND_NEAREST_EN -> C=32'h3F800002.
  - Without ROUND_NEAREST_EN -> C=32'h3F800002 (exact low bits discarded; compare against a golden model). Also apply A=32'h3FFFFFFF, B=32'h3FFFFFFF -> rounded C=32'h407FFFFE vs truncated 32'h407FFFFE, and check random vectors against a bit-accurate reference.
- Mid-stream reset: stream 5 distinct pairs and assert rst_n=1 for 1 cycle mid-stream -> C=0 and error_flag=0 on the edge after reset. Pre-reset operands never appear at the output; post-reset operands appear 3 edges after application.
